seg_bcd_encoder: RTL and testbench
==================================

# seg_bcd_encoder

Upstream feeder for the two-digit seven-segment multiplexer. Accepts an 8-bit binary value through a valid/ready handshake and converts it to two BCD digits with an iterative shift-add-3 engine. It encodes each digit into active-low segment lines a0..g0/dp0 (units) and a1..g1/dp1 (tens), and holds them stable between updates. It also generates the `clock_7s` refresh clock that the multiplexer runs on.

## Interface
- `REFRESH_DIV`, 50000, system cycles per half-period of `clock_7s` (≥1)
- `BLANK_LEADING`, 1, 1 = tens digit blanked when it is 0 and there is no overflow
- `clock`  in  1  system clock, all logic on rising edge
- `reset_n`  in  1  asynchronous, active-low reset; one clock domain
- `value`  in  8  binary value to display
- `dp_in`  in  2  decimal points; bit0→dp0, bit1→dp1, active-high request
- `value_valid`  in  1  `value`/`dp_in` offered
- `value_ready`  out  1  high when idle; transfer on `value_valid & value_ready`
- `a0,b0,c0,d0,e0,f0,g0,dp0`  out  1 each  units digit segments, active-low
- `a1,b1,c1,d1,e1,f1,g1,dp1`  out  1 each  tens digit segments, active-low
- `ovf`  out  1  last accepted value was >99
- `clock_7s`  out  1  registered refresh square wave

## Operation
- Reset (async assert): all segment and dp outputs 1 (dark), `ovf`=0, `value_ready`=1, `clock_7s`=0, prescaler=0, FSM=IDLE.
- FSM states:
  - IDLE: `value_ready`=1. On handshake, capture `value` into shift register `sr[7:0]` and `dp_in`, clear BCD register `bcd[11:0]` and iteration count, go to SHIFT.
  - SHIFT: 8 iterations, one per cycle. Each cycle first adds 3 to every BCD nibble ≥5, then shifts `{bcd,sr}` left by 1. After the 8th iteration go to LATCH.
  - LATCH: register outputs, then return to IDLE.
- LATCH rules:
  - Overflow: if the hundreds nibble ≠0, `ovf`=1 and both digits show "-" (only g low). Both dp follow `dp_in`.
  - Normal: `ovf`=0; units = encode(ones nibble), tens = encode(tens nibble).
  - Tens digit is fully dark (segments 1) when `BLANK_LEADING`=1 and the tens nibble is 0. The tens dp still follows `dp_in[1]`.
- Encoding is active-low, common anode. Bit order is gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Nibble codes 10–15 cannot occur; they encode as dark.
- Outputs change only in LATCH. Between updates they hold the last value.
- `value_valid` while busy is ignored (not queued). The upstream holds it until `value_ready`.
- Prescaler counts 0..REFRESH_DIV-1. `clock_7s` toggles on the wrap. It runs independently of the FSM.

## Timing
- Handshake at edge T. SHIFT occupies edges T+1..T+8. LATCH registers outputs at edge T+9. `value_ready` is high again after edge T+9. Back-to-back accept is possible at edge T+10.
- Throughput: one value per 10 cycles.
- `value_ready` is a registered FSM decode with no combinational path from `value_valid`.
- Reset mid-conversion: outputs go dark immediately and the partial result is discarded.
- `clock_7s` period = 2·REFRESH_DIV system cycles. The first rising edge comes REFRESH_DIV cycles after reset release.
- REFRESH_DIV=1: `clock_7s` toggles every cycle.

## Structure
- Shared package `seg_pkg`:
  - the 7-bit active-low digit constants (0–9, DASH, BLANK)
  - FSM state enum {IDLE, SHIFT, LATCH}
  - iteration count constant 8
- Sub-module `seg_encode`: combinational nibble→7-segment lookup, instantiated twice.
- Prescaler stays inline.

## Test plan
- Reset then idle: all segments/dp = 1, `ovf`=0, `value_ready`=1, `clock_7s`=0.
- `value`=42, `dp_in`=2'b00:
  - `value_ready` low for 9 cycles.
  - At T+9: tens gfedcba=0011001, units=0100100, dp0=dp1=1.
- `value`=7, `BLANK_LEADING`=1 then 0:
  - BLANK_LEADING=1: tens dark, units=1111000.
  - BLANK_LEADING=0: tens=1000000.
- `value`=200, `dp_in`=2'b01: `ovf`=1, both digits 0111111, dp0=0, dp1=1.
- Mid-operation events:
  - `value_valid` asserted with 99 during conversion of 15 → only 15 is displayed.
  - Reset at T+4 → outputs dark, next accepted 99 shows 0010000/0010000.
- `REFRESH_DIV`=4: `clock_7s` toggles every 4 cycles, period 8, unaffected by conversions.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the BCD seven-segment encoder: active-low digit
// patterns (bit order gfedcba), conversion FSM states and the double-dabble step.
package seg_pkg;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam int ITERATIONS = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LATCH = 2'd2
   } state_t;

   // Add 3 to every BCD nibble that is 5 or more, ahead of the left shift.
   function automatic logic [11:0] bcd_adjust(input logic [11:0] bcd);
      logic [11:0] adj;
      adj = bcd;
      for (int n = 0; n < 3; n++) begin
         if (bcd[n*4 +: 4] >= 4'd5) adj[n*4 +: 4] = bcd[n*4 +: 4] + 4'd3;
      end
      return adj;
   endfunction

endpackage

// File: rtl/seg_encode.sv
// Combinational BCD nibble to active-low seven-segment lookup (gfedcba).
module seg_encode
   import seg_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] seg
);

   // NOTE: every path through a combinational case assigns seg (default
   // branch included), so no latch is inferred.
   always_comb begin
      seg = SEG_BLANK;
      case (digit)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seg_bcd_encoder.sv
// Accepts an 8-bit value, converts it to two BCD digits with a shift-add-3
// engine, drives two active-low seven-segment digits and the refresh clock.
module seg_bcd_encoder
   import seg_pkg::*;
#(
   parameter int REFRESH_DIV   = 50000,
   parameter bit BLANK_LEADING = 1'b1
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [7:0] value,
   input  logic [1:0] dp_in,
   input  logic       value_valid,
   output logic       value_ready,
   output logic       a0,
   output logic       b0,
   output logic       c0,
   output logic       d0,
   output logic       e0,
   output logic       f0,
   output logic       g0,
   output logic       dp0,
   output logic       a1,
   output logic       b1,
   output logic       c1,
   output logic       d1,
   output logic       e1,
   output logic       f1,
   output logic       g1,
   output logic       dp1,
   output logic       ovf,
   output logic       clock_7s
);

   localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);

   state_t      state;
   state_t      state_next;
   logic [3:0]  iter;
   logic [7:0]  sr;
   logic [11:0] bcd;
   logic [1:0]  dp_cap;
   logic        load;
   logic        step;
   logic        latch_en;
   logic        last_iter;
   logic [6:0]  units_seg;
   logic [6:0]  tens_seg;
   logic [6:0]  seg0;
   logic [6:0]  seg1;
   logic [PW-1:0] pre;

   assign last_iter = (iter == 4'(ITERATIONS - 1));

   // NOTE: state and data registers use non-blocking assignments so every
   // flop samples pre-edge values regardless of statement order.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         value_ready <= 1'b1;
      end else begin
         state       <= state_next;
         value_ready <= (state_next == IDLE);
      end
   end

   always_comb begin
      state_next = state;
      load       = 1'b0;
      step       = 1'b0;
      latch_en   = 1'b0;
      case (state)
         IDLE: begin
            if (value_valid) begin
               load       = 1'b1;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            step = 1'b1;
            if (last_iter) state_next = LATCH;
         end
         LATCH: begin
            latch_en   = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // NOTE: conversion registers are reset too, so a reset mid-conversion
   // leaves no partial result behind.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sr     <= '0;
         bcd    <= '0;
         iter   <= '0;
         dp_cap <= '0;
      end else if (load) begin
         sr     <= value;
         dp_cap <= dp_in;
         bcd    <= '0;
         iter   <= '0;
      end else if (step) begin
         {bcd, sr} <= {bcd_adjust(bcd), sr} << 1;
         iter      <= iter + 4'd1;
      end
   end

   seg_encode u_units (
      .digit (bcd[3:0]),
      .seg   (units_seg)
   );

   seg_encode u_tens (
      .digit (bcd[7:4]),
      .seg   (tens_seg)
   );

   // Displayed digits only change on LATCH; a non-zero hundreds nibble means >99.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         seg0 <= SEG_BLANK;
         seg1 <= SEG_BLANK;
         dp0  <= 1'b1;
         dp1  <= 1'b1;
         ovf  <= 1'b0;
      end else if (latch_en) begin
         dp0 <= ~dp_cap[0];
         dp1 <= ~dp_cap[1];
         if (bcd[11:8] != 4'd0) begin
            ovf  <= 1'b1;
            seg0 <= SEG_DASH;
            seg1 <= SEG_DASH;
         end else begin
            ovf  <= 1'b0;
            seg0 <= units_seg;
            seg1 <= (BLANK_LEADING && bcd[7:4] == 4'd0) ? SEG_BLANK : tens_seg;
         end
      end
   end

   assign {g0, f0, e0, d0, c0, b0, a0} = seg0;
   assign {g1, f1, e1, d1, c1, b1, a1} = seg1;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pre      <= '0;
         clock_7s <= 1'b0;
      end else if (pre == PRE_LAST) begin
         pre      <= '0;
         clock_7s <= ~clock_7s;
      end else begin
         pre <= pre + 1'b1;
      end
   end

endmodule

// File: tb/tb_seg_bcd_encoder.sv
// Bench for seg_bcd_encoder: two instances (leading blank on/off, different
// refresh dividers) checked every cycle against a decimal-arithmetic model.
module tb_seg_bcd_encoder;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] value = '0;
   logic [1:0] dp_in = '0;
   logic       value_valid = 1'b0;

   logic ready_a, a0_a, b0_a, c0_a, d0_a, e0_a, f0_a, g0_a, dp0_a;
   logic a1_a, b1_a, c1_a, d1_a, e1_a, f1_a, g1_a, dp1_a, ovf_a, clk7_a;
   logic ready_b, a0_b, b0_b, c0_b, d0_b, e0_b, f0_b, g0_b, dp0_b;
   logic a1_b, b1_b, c1_b, d1_b, e1_b, f1_b, g1_b, dp1_b, ovf_b, clk7_b;

   int tests = 0;
   int fails = 0;

   always #5 clock = ~clock;

   seg_bcd_encoder #(.REFRESH_DIV(4), .BLANK_LEADING(1'b1)) dut_a (
      .clock(clock), .reset_n(reset_n), .value(value), .dp_in(dp_in),
      .value_valid(value_valid), .value_ready(ready_a),
      .a0(a0_a), .b0(b0_a), .c0(c0_a), .d0(d0_a), .e0(e0_a), .f0(f0_a), .g0(g0_a), .dp0(dp0_a),
      .a1(a1_a), .b1(b1_a), .c1(c1_a), .d1(d1_a), .e1(e1_a), .f1(f1_a), .g1(g1_a), .dp1(dp1_a),
      .ovf(ovf_a), .clock_7s(clk7_a)
   );

   seg_bcd_encoder #(.REFRESH_DIV(1), .BLANK_LEADING(1'b0)) dut_b (
      .clock(clock), .reset_n(reset_n), .value(value), .dp_in(dp_in),
      .value_valid(value_valid), .value_ready(ready_b),
      .a0(a0_b), .b0(b0_b), .c0(c0_b), .d0(d0_b), .e0(e0_b), .f0(f0_b), .g0(g0_b), .dp0(dp0_b),
      .a1(a1_b), .b1(b1_b), .c1(c1_b), .d1(d1_b), .e1(e1_b), .f1(f1_b), .g1(g1_b), .dp1(dp1_b),
      .ovf(ovf_b), .clock_7s(clk7_b)
   );

   wire [6:0] units_a = {g0_a, f0_a, e0_a, d0_a, c0_a, b0_a, a0_a};
   wire [6:0] tens_a  = {g1_a, f1_a, e1_a, d1_a, c1_a, b1_a, a1_a};
   wire [6:0] units_b = {g0_b, f0_b, e0_b, d0_b, c0_b, b0_b, a0_b};
   wire [6:0] tens_b  = {g1_b, f1_b, e1_b, d1_b, c1_b, b1_b, a1_b};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Digit patterns gfedcba, active-low, written out from the display table.
   function automatic logic [6:0] digit_pattern(input int d);
      logic [6:0] tbl [10];
      tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
      return tbl[d];
   endfunction

   // Model: a value is taken when idle and shown 9 edges later; busy otherwise.
   int         m_busy;
   int         m_val;
   logic [1:0] m_dp;
   int         m_shown;
   logic [1:0] m_shown_dp;
   bit         m_has;
   int         m_edges;

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         m_busy  <= 0;
         m_has   <= 1'b0;
         m_edges <= 0;
      end else begin
         m_edges <= m_edges + 1;
         if (m_busy == 0) begin
            if (value_valid) begin
               m_val  <= int'(value);
               m_dp   <= dp_in;
               m_busy <= 9;
            end
         end else begin
            m_busy <= m_busy - 1;
            if (m_busy == 1) begin
               m_shown    <= m_val;
               m_shown_dp <= m_dp;
               m_has      <= 1'b1;
            end
         end
      end
   end

   // Compare both instances against the model on every falling edge.
   always @(negedge clock) begin
      logic [6:0] e_units, e_tens_a, e_tens_b;
      logic       e_dp0, e_dp1, e_ovf;
      e_units = 7'h7f; e_tens_a = 7'h7f; e_tens_b = 7'h7f;
      e_dp0 = 1'b1; e_dp1 = 1'b1; e_ovf = 1'b0;
      if (m_has) begin
         e_dp0 = ~m_shown_dp[0];
         e_dp1 = ~m_shown_dp[1];
         if (m_shown > 99) begin
            e_ovf = 1'b1; e_units = 7'b0111111; e_tens_a = 7'b0111111; e_tens_b = 7'b0111111;
         end else begin
            e_units  = digit_pattern(m_shown % 10);
            e_tens_b = digit_pattern(m_shown / 10);
            e_tens_a = (m_shown / 10 == 0) ? 7'h7f : digit_pattern(m_shown / 10);
         end
      end
      check("ready_a", ready_a, m_busy == 0);
      check("ready_b", ready_b, m_busy == 0);
      check("units_a", units_a, e_units);
      check("units_b", units_b, e_units);
      check("tens_a", tens_a, e_tens_a);
      check("tens_b", tens_b, e_tens_b);
      check("dp_a", {dp1_a, dp0_a}, {e_dp1, e_dp0});
      check("dp_b", {dp1_b, dp0_b}, {e_dp1, e_dp0});
      check("ovf_a", ovf_a, e_ovf);
      check("ovf_b", ovf_b, e_ovf);
      check("clk7_a", clk7_a, ((m_edges / 4) % 2) == 1);
      check("clk7_b", clk7_b, (m_edges % 2) == 1);
   end

   // Offer a value and wait (bounded) for the handshake edge.
   task automatic send(input logic [7:0] v, input logic [1:0] dp);
      bit done = 1'b0;
      value = v; dp_in = dp; value_valid = 1'b1;
      for (int i = 0; i < 30 && !done; i++) begin
         @(negedge clock);
         if (ready_a) begin
            @(posedge clock);
            #1 value_valid = 1'b0;
            done = 1'b1;
         end
      end
      if (!done) begin
         tests++; fails++;
         $display("FAIL handshake_timeout: value %0d never accepted", v);
         value_valid = 1'b0;
      end
   endtask

   task automatic settle();
      repeat (9) @(posedge clock);
      @(negedge clock);
   endtask

   initial begin
      repeat (3) @(posedge clock);
      #1 reset_n = 1'b1;
      @(negedge clock);
      check("rst_units", units_a, 7'h7f);
      check("rst_ready", ready_a, 1'b1);

      send(8'd42, 2'b00);
      settle();
      check("lit42_tens", tens_a, 7'b0011001);
      check("lit42_units", units_a, 7'b0100100);
      check("lit42_dp", {dp1_a, dp0_a}, 2'b11);

      send(8'd7, 2'b10);
      settle();
      check("lit7_tens_blank", tens_a, 7'b1111111);
      check("lit7_units", units_a, 7'b1111000);
      check("lit7_tens_zero", tens_b, 7'b1000000);
      check("lit7_dp1", dp1_b, 1'b0);

      send(8'd200, 2'b01);
      settle();
      check("lit200_ovf", ovf_a, 1'b1);
      check("lit200_tens", tens_a, 7'b0111111);
      check("lit200_units", units_b, 7'b0111111);
      check("lit200_dp", {dp1_a, dp0_a}, 2'b10);

      send(8'd255, 2'b11);
      settle();
      send(8'd100, 2'b00);
      settle();
      send(8'd99, 2'b00);
      settle();
      send(8'd10, 2'b00);
      settle();

      // A second offer while busy must be dropped, not queued.
      send(8'd15, 2'b00);
      value = 8'd99; value_valid = 1'b1;
      repeat (5) @(posedge clock);
      #1 value_valid = 1'b0;
      repeat (6) @(posedge clock);
      @(negedge clock);
      check("lit15_units", units_a, 7'b0010010);
      check("lit15_tens", tens_a, 7'b1111001);

      // Back-to-back offers.
      send(8'd0, 2'b00);
      send(8'd58, 2'b01);
      settle();
      check("lit58_units", units_b, 7'b0000000);

      // Reset during a conversion.
      send(8'd88, 2'b11);
      repeat (3) @(posedge clock);
      #1 reset_n = 1'b0;
      #1;
      check("midrst_units", units_a, 7'h7f);
      check("midrst_dp", dp0_a, 1'b1);
      @(posedge clock);
      #1 reset_n = 1'b1;
      send(8'd99, 2'b00);
      settle();
      check("lit99_units", units_a, 7'b0010000);
      check("lit99_tens", tens_a, 7'b0010000);

      repeat (12) @(posedge clock);
      @(negedge clock);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
